// File: rtl/cnt_seq_ctrl_pkg.sv
// Shared types for the count-sequence controller: state encoding and default width.
package cnt_seq_ctrl_pkg;

   localparam int W_DEF = 8;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LOAD = 3'd1,
      ST_RUN  = 3'd2,
      ST_DONE = 3'd3,
      ST_ABRT = 3'd4
   } state_t;

endpackage

// File: rtl/cnt_seq_ctrl_sat_counter.sv
// W-bit up-counter that sticks at all-ones; clear has priority over enable.
module cnt_seq_ctrl_sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] q
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q <= '0;
      end else if (clr) begin
         q <= '0;
      end else if (en && (q != {W{1'b1}})) begin
         q <= q + 1'b1;
      end
   end

endmodule

// File: rtl/cnt_seq_ctrl.sv
// Sequencer in front of the external loadable down-counter: load, step while ready, finish on co=0.
// Handshake: a step happens in any RUN cycle with co=1, ready=1 and abort=0; shift_en and cnt are that step.
module cnt_seq_ctrl
   import cnt_seq_ctrl_pkg::*;
#(
   parameter int W = W_DEF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] len,
   input  logic         ready,
   input  logic         abort,
   input  logic         co,
   output logic         ld_cnt,
   output logic         cnt,
   output logic [W-1:0] init,
   output logic         shift_en,
   output logic         busy,
   output logic         done,
   output logic         aborted,
   output logic [W-1:0] stall_cnt,
   output state_t       dbg_state
);

   state_t state;
   state_t state_nxt;
   logic   accept;
   logic   len_nz;
   logic   step;
   logic   stall;

   assign len_nz = (len != '0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      step      = 1'b0;
      stall     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               accept    = 1'b1;
               state_nxt = len_nz ? ST_LOAD : ST_DONE;
            end
         end
         ST_LOAD: begin
            state_nxt = ST_RUN;
         end
         ST_RUN: begin
            if (abort) begin
               state_nxt = ST_ABRT;
            end else if (!co) begin
               state_nxt = ST_DONE;
            end else if (ready) begin
               step = 1'b1;
            end else begin
               stall = 1'b1;
            end
         end
         ST_DONE: begin
            state_nxt = ST_IDLE;
         end
         ST_ABRT: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // ld_cnt comes straight from a flop because the counter loads asynchronously on it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ld_cnt <= 1'b0;
         init   <= '0;
      end else begin
         ld_cnt <= accept && len_nz;
         if (accept && len_nz) begin
            init <= len;
         end
      end
   end

   cnt_seq_ctrl_sat_counter #(.W(W)) u_stall (
      .clk (clk),
      .rst (rst),
      .clr (accept),
      .en  (stall),
      .q   (stall_cnt)
   );

   assign cnt       = step;
   assign shift_en  = step;
   assign busy      = (state != ST_IDLE);
   assign done      = (state == ST_DONE);
   assign aborted   = (state == ST_ABRT);
   assign dbg_state = state;

endmodule

// File: tb/tb_cnt_seq_ctrl.sv
// Bench for cnt_seq_ctrl with a behavioural down-counter attached; sequence results are scored on done/aborted.
module tb_cnt_seq_ctrl;
   import cnt_seq_ctrl_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] len;
   logic       ready;
   logic       abort;
   logic       co;
   logic       ld_cnt;
   logic       cnt;
   logic [7:0] init;
   logic       shift_en;
   logic       busy;
   logic       done;
   logic       aborted;
   logic [7:0] stall_cnt;
   state_t     dbg_state;

   cnt_seq_ctrl #(.W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .len       (len),
      .ready     (ready),
      .abort     (abort),
      .co        (co),
      .ld_cnt    (ld_cnt),
      .cnt       (cnt),
      .init      (init),
      .shift_en  (shift_en),
      .busy      (busy),
      .done      (done),
      .aborted   (aborted),
      .stall_cnt (stall_cnt),
      .dbg_state (dbg_state)
   );

   // clock / reset block
   always #5 clk = ~clk;

   // stand-in for the external down-counter
   logic [7:0] q_cnt = '0;
   always @(posedge clk) begin
      if (ld_cnt) q_cnt <= init;
      else if (cnt) q_cnt <= q_cnt - 8'd1;
   end
   assign co = (q_cnt != 8'd0);

   typedef struct packed {
      logic [1:0]  kind;     // {done, aborted}
      logic [15:0] lat;      // cycles from the start-presenting cycle to the pulse
      logic [8:0]  shifts;
      logic [7:0]  stall;
      logic [1:0]  lds;
      logic [7:0]  cnt_end;  // counter value while the pulse is high
   } res_t;

   typedef struct {
      int   len;
      int   stall_at;
      int   stall_len;
      int   abort_after;
      int   busy_start;
      res_t exp;
   } vec_t;

   res_t exp_q[$];
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   start_cyc = 0;
   int   shifts = 0;
   int   lds = 0;
   int   busys = 0;
   bit   seq_end = 0;
   int   exp_init = 0;
   vec_t vecs[11];

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc++;

   // scoreboard monitor
   always @(negedge clk) begin
      res_t e;
      if (rst) begin
         check("cnt_vs_shift_en", shift_en, cnt);
         check("step_outside_busy", shift_en && !busy, 0);
         if (shift_en) shifts++;
         if (ld_cnt)   lds++;
         if (busy)     busys++;
         if (done || aborted) begin
            if (exp_q.size() == 0) begin
               check("unexpected_pulse", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check("kind",      {done, aborted}, e.kind);
               check("latency",   cyc - start_cyc, e.lat);
               check("shifts",    shifts, e.shifts);
               check("stall_cnt", stall_cnt, e.stall);
               check("ld_cycles", lds, e.lds);
               check("cnt_end",   q_cnt, e.cnt_end);
               check("busy_cyc",  busys, e.lat);
            end
            seq_end = 1;
         end
      end
   end

   function automatic vec_t mk(input int l, input int sa, input int sl, input int ab, input int bs,
                               input int kind, input int lat, input int sh, input int st,
                               input int ld, input int ce);
      vec_t v;
      v.len = l; v.stall_at = sa; v.stall_len = sl; v.abort_after = ab; v.busy_start = bs;
      v.exp.kind = 2'(kind); v.exp.lat = 16'(lat); v.exp.shifts = 9'(sh);
      v.exp.stall = 8'(st); v.exp.lds = 2'(ld); v.exp.cnt_end = 8'(ce);
      return v;
   endfunction

   task automatic run_vec(input vec_t v);
      int k;
      bit ab_done;
      exp_q.push_back(v.exp);
      @(posedge clk); #1;
      start = 1'b1; len = 8'(v.len); ready = 1'b1; abort = 1'b0;
      start_cyc = cyc; shifts = 0; lds = 0; busys = 0; seq_end = 0;
      ab_done = 0; k = 0;
      while (!seq_end && k < 400) begin
         @(posedge clk); #1;
         k = cyc - start_cyc;
         start = (k == v.busy_start);
         len   = start ? 8'd99 : 8'hA5;
         ready = !(k >= v.stall_at && k < v.stall_at + v.stall_len);
         abort = 1'b0;
         if (v.abort_after >= 0 && !ab_done && k >= 2 && shifts == v.abort_after) begin
            abort = 1'b1;
            ab_done = 1;
         end
      end
      start = 1'b0; abort = 1'b0;
      if (!seq_end) begin
         check("seq_timeout", 0, 1);
         if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      if (v.len != 0) exp_init = v.len;
      @(negedge clk);
      check("busy_after", busy, 0);
      check("init_hold", init, exp_init);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int l, sa, sl;
      rst = 1'b0; start = 1'b0; len = '0; ready = 1'b0; abort = 1'b0;

      // fixed table: len, stall_at, stall_len, abort_after, busy_start, kind, lat, shifts, stall, lds, cnt_end
      vecs[0] = mk(5,   0, 0,   -1, -1, 2, 8,   5,   0,   1, 0);
      vecs[1] = mk(4,   3, 3,   -1, -1, 2, 10,  4,   3,   1, 0);
      vecs[2] = mk(0,   0, 0,   -1, -1, 2, 1,   0,   0,   0, 0);
      vecs[3] = mk(10,  0, 0,    3,  3, 1, 6,   3,   0,   1, 7);
      vecs[4] = mk(2,   2, 300, -1, -1, 2, 305, 2,   255, 1, 0);
      vecs[5] = mk(1,   0, 0,   -1, -1, 2, 4,   1,   0,   1, 0);
      vecs[6] = mk(255, 0, 0,   -1, -1, 2, 258, 255, 0,   1, 0);
      for (int i = 7; i < 11; i++) begin
         l  = $urandom_range(1, 40);
         sl = $urandom_range(0, 6);
         sa = $urandom_range(2, 1 + l);
         vecs[i] = mk(l, sa, sl, -1, -1, 2, l + 3 + sl, l, sl, 1, 0);
      end

      repeat (3) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_ld", ld_cnt, 0);
      check("rst_shift", shift_en, 0);
      check("rst_done", done, 0);
      check("rst_abrt", aborted, 0);
      check("rst_stall", stall_cnt, 0);
      check("rst_init", init, 0);
      @(posedge clk); #1 rst = 1'b1;
      @(negedge clk);
      check("idle_busy", busy, 0);
      check("idle_state", dbg_state, ST_IDLE);

      for (int i = 0; i < 11; i++) run_vec(vecs[i]);

      // reset in the middle of a stalled run
      @(posedge clk); #1;
      start = 1'b1; len = 8'd20; ready = 1'b0; start_cyc = cyc;
      @(posedge clk); #1 start = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      check("mid_busy", busy, 1);
      check("mid_stall", stall_cnt, 3);
      #2 rst = 1'b0;
      #1;
      check("mid_rst_busy", busy, 0);
      check("mid_rst_ld", ld_cnt, 0);
      check("mid_rst_shift", shift_en, 0);
      check("mid_rst_stall", stall_cnt, 0);
      check("mid_rst_init", init, 0);
      check("mid_rst_pulse", done || aborted, 0);
      exp_init = 0;
      repeat (2) @(negedge clk);
      rst = 1'b1; ready = 1'b1;

      run_vec(vecs[0]);
      check("queue_empty", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cnt_seq_ctrl.md
Name: cnt_seq_ctrl

Overview:
- Control stage that sits directly upstream of the 8-bit loadable down-counter and consumes its `co` (count-nonzero) flag.
- Accepts a start request with a length, then:
  - loads the counter;
  - issues one decrement per cycle in which the downstream datapath is ready;
  - emits a per-step enable;
  - signals completion with a one-cycle done pulse.
- Also provides an abort path and a saturating stall counter for debug.

Parameters:
- W, 8, width of length, counter init value and stall counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset; all flops clear while low.
- start  input  1  request to begin a sequence; sampled only in IDLE.
- len  input  W  sequence length; latched when start is accepted.
- ready  input  1  downstream can accept a step this cycle.
- abort  input  1  synchronous cancel of an active sequence.
- co  input  1  counter nonzero flag from the down-counter.
- ld_cnt  output  1  counter load strobe, registered (glitch-free, because the counter treats it as an asynchronous load).
- cnt  output  1  counter decrement enable.
- init  output  W  counter load value.
- shift_en  output  1  one step issued to the datapath this cycle.
- busy  output  1  sequence in progress (state != IDLE).
- done  output  1  one-cycle pulse on normal completion.
- aborted  output  1  one-cycle pulse on abort.
- stall_cnt  output  W  stall cycles in the current/last sequence, saturating.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE;
  - init=0, stall_cnt=0;
  - ld_cnt, cnt, shift_en, busy, done, aborted = 0.
- States: IDLE, LOAD, RUN, DONE, ABRT. Encoding is 3-bit binary.
- IDLE:
  - busy=0.
  - start=1 with len!=0: init<=len, stall_cnt<=0, ld_cnt flop<=1, next state LOAD.
  - start=1 with len==0: stall_cnt<=0, init unchanged, no load, next state DONE.
- LOAD:
  - ld_cnt=1 for exactly this cycle; the counter holds len from the next cycle.
  - Next state RUN unconditionally. abort is ignored in LOAD.
- RUN (evaluated in priority order):
  - abort=1: next state ABRT; no cnt/shift_en this cycle.
  - co=0: next state DONE; cnt=0.
  - ready=1: cnt=1, shift_en=1; stay in RUN.
  - ready=0: cnt=0, shift_en=0; stall_cnt increments, saturating at 2^W-1; stay in RUN.
- DONE: done=1 for one cycle; next state IDLE.
- ABRT: aborted=1 for one cycle; next state IDLE. The counter value is left as-is.
- cnt and shift_en are combinational from state, co, ready and abort. They are identical and never asserted outside RUN.
- Latency:
  - start accepted at edge E: ld_cnt high in cycle E+1, first possible shift_en in cycle E+2.
  - With ready held high and len=N: exactly N shift_en cycles, then done is high N+3 cycles after start.
- start while busy is ignored. len changes after acceptance have no effect.
- stall_cnt holds its value in IDLE until the next accepted start.
- init holds its last loaded value.
- ready is don't-care outside RUN.
- Reset mid-sequence: immediate return to reset values; no done or aborted pulse.

Decomposition:
- Shared package holds:
  - state typedef/localparams: ST_IDLE=0, ST_LOAD=1, ST_RUN=2, ST_DONE=3, ST_ABRT=4;
  - default width W=8.
- One natural sub-module, sat_counter: W-bit saturating up-counter with clear and enable, used for stall_cnt.
- The down-counter itself stays external and is instantiated alongside in the parent.

Test Plan:
- Reset held low 3 cycles, then released -> all outputs 0, busy=0, stall_cnt=0.
- start with len=5, ready=1 constant, counter attached -> ld_cnt one cycle, shift_en exactly 5 cycles, done one cycle at start+8, stall_cnt=0.
- start with len=4, ready low on 3 cycles mid-run -> 4 shift_en pulses, stall_cnt=3, done at start+10.
- start with len=0 -> no ld_cnt, no shift_en, done the cycle after acceptance, busy high one cycle.
- start with len=10, abort after 3 shift_en -> aborted pulse, done never asserted, counter remains at 7, busy drops next cycle; a second start while busy is ignored.
- W=8, len=2, ready held low 300 cycles then high -> stall_cnt saturates at 255, 2 shift_en pulses, then done.
